// File: rtl/payload_engine_pkg.sv
// payload_engine_pkg
//   Shared definitions for the programmable payload engines.
//   - CLS_W       : class-select field width ($clog2 of the class bus width)
//   - cfg word    : slot word {loop, sel}, control word {anchor, len}, both LSB-first
//   - ctrl_addr() : address of the control word for an engine with n state slots
//   - slot_cfg_t  : per-state slot configuration
package payload_engine_pkg;

    localparam int unsigned CLS_W  = 6;
    localparam int unsigned CFG_W  = CLS_W + 1;

    // Slot word layout
    localparam int unsigned SEL_LSB  = 0;
    localparam int unsigned LOOP_BIT = CLS_W;

    // Control word layout; the len field spans everything below the anchor bit
    localparam int unsigned LEN_LSB    = 0;
    localparam int unsigned LEN_FW     = CLS_W;
    localparam int unsigned ANCHOR_BIT = CLS_W;

    localparam int unsigned NFA_MAX_STATES = 16;

    typedef struct packed {
        logic             loop;
        logic [CLS_W-1:0] sel;
    } slot_cfg_t;

    // The control word sits directly after the last state slot.
    function automatic int unsigned ctrl_addr(input int unsigned num_states);
        return num_states;
    endfunction

endpackage

// File: rtl/engine_nfa_cell.sv
// engine_nfa_cell
//   One NFA state position.
//   Ports:
//     clk, rst_n : clock, async active-low reset
//     cls_hit    : current byte matches this position's class (already len-masked)
//     prev       : predecessor term (previous state, or start term for position 0)
//     loop       : "+" self-loop enable for this position
//     clr        : synchronous clear of the state flop (wins over en)
//     en         : byte valid
//     nxt        : combinational next-state value for the current byte
//     s          : state flop
module engine_nfa_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic cls_hit,
    input  logic prev,
    input  logic loop,
    input  logic clr,
    input  logic en,
    output logic nxt,
    output logic s
);

    assign nxt = cls_hit & (prev | (loop & s));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s <= 1'b0;
        end else if (clr) begin
            s <= 1'b0;
        end else if (en) begin
            s <= nxt;
        end
    end

endmodule

// File: rtl/engine_nfa_prog.sv
// engine_nfa_prog
//   Runtime-programmable NFA class-sequence matcher with optional "+" loops.
//   Build option: define MATCH_POS_EN to add the byte counter and match_pos
//   register; otherwise match_pos is tied to 0.
//   Ports:
//     clk, rst_n : clock, async active-low reset
//     sod        : start of data, clears per-packet state (priority over en)
//     en         : byte valid
//     cls        : class-hit bus for the current byte
//     cfg_we     : config write strobe (also clears the state vector)
//     cfg_addr   : 0..NUM_STATES-1 slot, NUM_STATES control word
//     cfg_wdata  : slot {loop, sel} or control {anchor, len}
//     out        : sticky match flag
//     match_pos  : byte offset of the byte completing the first match
module engine_nfa_prog
    import payload_engine_pkg::*;
#(
    parameter int unsigned NUM_STATES  = NFA_MAX_STATES,
    parameter int unsigned NUM_CLASSES = 64,
    parameter int unsigned POS_W       = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              sod,
    input  logic                              en,
    input  logic [NUM_CLASSES-1:0]            cls,
    input  logic                              cfg_we,
    input  logic [$clog2(NUM_STATES+1)-1:0]   cfg_addr,
    input  logic [CLS_W:0]                    cfg_wdata,
    output logic                              out,
    output logic [POS_W-1:0]                  match_pos
);

    localparam int unsigned AW = $clog2(NUM_STATES + 1);
    localparam int unsigned LW = $clog2(NUM_STATES + 1);

    slot_cfg_t             slot_q [NUM_STATES];
    logic [LW-1:0]         len_q;
    logic                  anchor_q;
    logic                  first_q;
    logic                  out_q;

    logic [NUM_STATES-1:0] s_q;
    logic [NUM_STATES-1:0] s_nxt;
    logic [NUM_STATES-1:0] cls_hit;
    logic [NUM_STATES-1:0] prev;
    logic [NUM_STATES-1:0] loop_eff;
    logic                  clr;
    logic                  p0;
    logic                  match;
    logic [LEN_FW-1:0]     len_field;

    assign len_field = cfg_wdata[LEN_LSB +: LEN_FW];

    // Configuration registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_STATES; i++) begin
                slot_q[i] <= '0;
            end
            len_q    <= '0;
            anchor_q <= 1'b0;
        end else if (cfg_we) begin
            for (int unsigned i = 0; i < NUM_STATES; i++) begin
                if (cfg_addr == AW'(i)) begin
                    slot_q[i].loop <= cfg_wdata[LOOP_BIT];
                    slot_q[i].sel  <= cfg_wdata[SEL_LSB +: CLS_W];
                end
            end
            if (cfg_addr == AW'(ctrl_addr(NUM_STATES))) begin
                anchor_q <= cfg_wdata[ANCHOR_BIT];
                if (int'(len_field) > int'(NUM_STATES)) begin
                    len_q <= LW'(NUM_STATES);
                end else begin
                    len_q <= LW'(len_field);
                end
            end
        end
    end

    // Anchor window: open from reset / sod until the first enabled byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_q <= 1'b1;
        end else if (sod && !en) begin
            first_q <= 1'b1;
        end else if (en) begin
            first_q <= 1'b0;
        end
    end

    // A byte arriving together with sod is evaluated against an empty state
    // vector: predecessor and self-loop terms are gated with sod rather than
    // clearing the flops first.
    always_comb begin
        p0       = !anchor_q || first_q || sod;
        prev     = '0;
        cls_hit  = '0;
        loop_eff = '0;
        prev[0]  = p0;
        for (int unsigned i = 0; i < NUM_STATES; i++) begin
            cls_hit[i]  = cls[slot_q[i].sel] & (LW'(i) < len_q);
            loop_eff[i] = slot_q[i].loop & ~sod;
        end
        for (int unsigned i = 1; i < NUM_STATES; i++) begin
            prev[i] = s_q[i-1] & ~sod;
        end
    end

    // The match uses the pre-write config; cfg_we only clears afterwards.
    always_comb begin
        match = 1'b0;
        for (int unsigned i = 0; i < NUM_STATES; i++) begin
            if (LW'(i + 1) == len_q) begin
                match = s_nxt[i];
            end
        end
    end

    assign clr = cfg_we | (sod & ~en);

    for (genvar g = 0; g < NUM_STATES; g++) begin : g_cell
        engine_nfa_cell u_cell (
            .clk     (clk),
            .rst_n   (rst_n),
            .cls_hit (cls_hit[g]),
            .prev    (prev[g]),
            .loop    (loop_eff[g]),
            .clr     (clr),
            .en      (en),
            .nxt     (s_nxt[g]),
            .s       (s_q[g])
        );
    end

    // Sticky match flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= 1'b0;
        end else if (sod && !en) begin
            out_q <= 1'b0;
        end else if (en) begin
            out_q <= match | (out_q & ~sod);
        end
    end

    assign out = out_q;

`ifdef MATCH_POS_EN
    logic [POS_W-1:0] cnt_q;
    logic [POS_W-1:0] pos_q;
    logic [POS_W-1:0] cur_cnt;

    // Offset of the byte being presented; a sod byte is offset 0.
    assign cur_cnt = sod ? '0 : cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            pos_q <= '0;
        end else if (sod && !en) begin
            cnt_q <= '0;
            pos_q <= '0;
        end else if (en) begin
            cnt_q <= (cur_cnt == '1) ? cur_cnt : cur_cnt + 1'b1;
            if (sod) begin
                pos_q <= match ? cur_cnt : '0;
            end else if (match && !out_q) begin
                pos_q <= cur_cnt;
            end
        end
    end

    assign match_pos = pos_q;
`else
    assign match_pos = '0;
`endif

endmodule
